// File: rtl/shreg_pkg.sv
// Shared types and constants for the shift-register sequencer.
package shreg_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/shreg_seq.sv
// Sequencer driving a universal shift register:
// one parallel load, then a clamped number of serial steps.
module shreg_seq
    import shreg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic             abort,
    output logic             ld,
    output logic             sl,
    output logic             sr,
    output logic [WIDTH-1:0] D,
    output logic             D_sl,
    output logic             D_sr,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_clamp;
    logic             dir_q;
    logic             fill_q;

    assign cmd_ready = (state == IDLE) && !abort;

    assign cnt_clamp = (cmd_cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            dir_q  <= DIR_LEFT;
            fill_q <= 1'b0;
            ld     <= 1'b0;
            sl     <= 1'b0;
            sr     <= 1'b0;
            D      <= '0;
            D_sl   <= 1'b0;
            D_sr   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ld   <= 1'b0;
                    sl   <= 1'b0;
                    sr   <= 1'b0;
                    D    <= '0;
                    D_sl <= 1'b0;
                    D_sr <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        state  <= LOAD;
                        dir_q  <= cmd_dir;
                        fill_q <= cmd_fill;
                        cnt    <= cnt_clamp;
                        D      <= cmd_data;
                        ld     <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    ld <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        D     <= '0;
                        busy  <= 1'b0;
                    end else if (cnt != '0) begin
                        state <= SHIFT;
                        sl    <= (dir_q == DIR_LEFT);
                        sr    <= (dir_q == DIR_RIGHT);
                        D_sl  <= (dir_q == DIR_LEFT) && fill_q;
                        D_sr  <= (dir_q == DIR_RIGHT) && fill_q;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // cnt holds the steps remaining including the one shown now
                    if (abort || cnt == CNT_W'(1)) begin
                        state <= abort ? IDLE : DONE;
                        cnt   <= '0;
                        sl    <= 1'b0;
                        sr    <= 1'b0;
                        D_sl  <= 1'b0;
                        D_sr  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= !abort;
                        if (abort) begin
                            D <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                    D     <= '0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shreg_seq.sv
// Scoreboard bench: shreg_seq driving a behavioural 4-bit shift register.
module tb_shreg_seq;
    import shreg_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [2:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic       cmd_fill;
    logic       abort;
    logic       ld;
    logic       sl;
    logic       sr;
    logic [3:0] D;
    logic       D_sl;
    logic       D_sr;
    logic       busy;
    logic       done;

    logic [3:0] q;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_edge = 0;
    int n_ld = 0;
    int n_sl = 0;
    int n_sr = 0;
    bit chk_idle = 0;

    typedef struct {
        logic [3:0] data;
        logic       dir;
        logic       fill;
        int         steps;
        int         lat;
        logic [3:0] q;
        logic       aborted;
    } exp_t;

    exp_t exp_q[$];

    shreg_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_cnt(cmd_cnt),
        .cmd_data(cmd_data),
        .cmd_fill(cmd_fill),
        .abort(abort),
        .ld(ld),
        .sl(sl),
        .sr(sr),
        .D(D),
        .D_sl(D_sl),
        .D_sr(D_sr),
        .busy(busy),
        .done(done)
    );

    // behavioural 4-bit universal shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= D;
        end else if (sl) begin
            q <= {q[2:0], D_sl};
        end else if (sr) begin
            q <= {D_sr, q[3:1]};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    // monitor: compares DUT activity against the front of the queue
    always @(negedge clk) begin
        exp_t cur;
        if (!rst_n) begin
            n_ld = 0;
            n_sl = 0;
            n_sr = 0;
            chk_idle = 0;
        end else begin
            if (chk_idle) begin
                chk("abort_idle_busy", 32'(busy), 0);
                chk("abort_idle_strobes", 32'({ld, sl, sr}), 0);
                chk("abort_no_done", 32'(done), 0);
                chk("abort_idle_D", 32'(D), 0);
                chk_idle = 0;
            end
            if (ld || sl || sr || done || (abort && busy)) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_activity");
                end else begin
                    cur = exp_q[0];
                    chk("strobe_onehot",
                        32'($countones({ld, sl, sr}) <= 1), 1);
                    if (ld) begin
                        n_ld++;
                        chk("ld_data", 32'(D), 32'(cur.data));
                    end
                    if (sl) begin
                        n_sl++;
                        chk("sl_fill", 32'(D_sl), 32'(cur.fill));
                        chk("sl_unused_sr", 32'(D_sr), 0);
                        chk("sl_hold_D", 32'(D), 32'(cur.data));
                    end
                    if (sr) begin
                        n_sr++;
                        chk("sr_fill", 32'(D_sr), 32'(cur.fill));
                        chk("sr_unused_sl", 32'(D_sl), 0);
                        chk("sr_hold_D", 32'(D), 32'(cur.data));
                    end
                    if (abort && busy) begin
                        void'(exp_q.pop_front());
                        chk("abort_expected", 32'(cur.aborted), 1);
                        chk("abort_steps", cur.dir ? n_sr : n_sl, cur.steps);
                        chk_idle = 1;
                    end else if (done) begin
                        void'(exp_q.pop_front());
                        chk("done_not_aborted", 32'(cur.aborted), 0);
                        chk("ld_count", n_ld, 1);
                        chk("step_count", cur.dir ? n_sr : n_sl, cur.steps);
                        chk("other_dir_steps", cur.dir ? n_sl : n_sr, 0);
                        chk("done_latency", cyc - acc_edge, cur.lat);
                        chk("q_result", 32'(q), 32'(cur.q));
                        chk("done_strobes", 32'({ld, sl, sr}), 0);
                        chk("done_busy", 32'(busy), 0);
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                acc_edge = cyc + 1;
                n_ld = 0;
                n_sl = 0;
                n_sr = 0;
            end
        end
    end

    task automatic push(input logic dir, input logic [3:0] d,
                        input logic f, input int steps, input int lat,
                        input logic [3:0] qx, input logic ab);
        exp_t e;
        e.data = d;
        e.dir = dir;
        e.fill = f;
        e.steps = steps;
        e.lat = lat;
        e.q = qx;
        e.aborted = ab;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic dir, input logic [2:0] c,
                         input logic [3:0] d, input logic f);
        cmd_dir = dir;
        cmd_cnt = c;
        cmd_data = d;
        cmd_fill = f;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 50) begin
                fail("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (!busy && !done) break;
            n++;
            if (n > 50) begin
                fail("idle_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic dir, input logic [2:0] c,
                         input logic [3:0] d, input logic f,
                         input int steps, input int lat,
                         input logic [3:0] qx);
        push(dir, d, f, steps, lat, qx, 1'b0);
        drive(dir, c, d, f);
        wait_accept();
        cmd_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir = DIR_LEFT;
        cmd_cnt = '0;
        cmd_data = '0;
        cmd_fill = 1'b0;
        abort = 1'b0;
        #3;
        chk("rst_outputs", 32'({ld, sl, sr, D, D_sl, D_sr, busy, done}), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // shift cases: dir, cnt, data, fill, steps, done edges, Q
        issue(DIR_LEFT, 3'd1, 4'b1010, 1'b0, 1, 2, 4'b0100);
        issue(DIR_RIGHT, 3'd2, 4'b1010, 1'b1, 2, 3, 4'b1110);
        issue(DIR_LEFT, 3'd0, 4'b0101, 1'b0, 0, 1, 4'b0101);
        issue(DIR_LEFT, 3'd7, 4'b0110, 1'b1, 4, 5, 4'b1111);
        issue(DIR_RIGHT, 3'd4, 4'b1111, 1'b0, 4, 5, 4'b0000);
        chk("idle_D_zero", 32'(D), 0);

        // abort together with cmd_valid in IDLE blocks acceptance
        abort = 1'b1;
        drive(DIR_RIGHT, 3'd1, 4'b1000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_blocks_ready", 32'(cmd_ready), 0);
            chk("abort_blocks_busy", 32'(busy), 0);
        end
        @(posedge clk);
        #1;
        push(DIR_RIGHT, 4'b1000, 1'b1, 1, 2, 4'b1100, 1'b0);
        abort = 1'b0;
        wait_accept();
        cmd_valid = 1'b0;
        wait_idle();

        // abort on the 2nd of 3 left steps; a held request follows
        push(DIR_LEFT, 4'b1010, 1'b0, 2, 0, 4'b0000, 1'b1);
        drive(DIR_LEFT, 3'd3, 4'b1010, 1'b0);
        wait_accept();
        push(DIR_RIGHT, 4'b0011, 1'b0, 1, 2, 4'b0001, 1'b0);
        drive(DIR_RIGHT, 3'd1, 4'b0011, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_accept();
        cmd_valid = 1'b0;
        wait_idle();

        // reset in the middle of SHIFT
        push(DIR_LEFT, 4'b0001, 1'b1, 4, 5, 4'b1111, 1'b0);
        drive(DIR_LEFT, 3'd4, 4'b0001, 1'b1);
        wait_accept();
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        chk("mid_shift_busy", 32'(busy), 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_outputs",
            32'({ld, sl, sr, D, D_sl, D_sr, busy, done}), 0);
        chk("async_rst_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_done", 32'(done), 0);
        @(posedge clk);
        #1;
        issue(DIR_LEFT, 3'd2, 4'b0011, 1'b0, 2, 3, 4'b1100);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
